// File: rtl/riscv_mem_pkg.sv
// Shared memory-path definitions for the RISC-V core: load/store opcodes and
// the load FSM state encoding.
package riscv_mem_pkg;

    localparam logic [3:0] LD_LW  = 4'b0100;
    localparam logic [3:0] LD_LH  = 4'b0101;
    localparam logic [3:0] LD_LB  = 4'b0110;
    localparam logic [3:0] LD_LHU = 4'b0001;
    localparam logic [3:0] LD_LBU = 4'b0010;

    localparam logic [3:0] ST_SW  = 4'b1000;
    localparam logic [3:0] ST_SH  = 4'b1001;
    localparam logic [3:0] ST_SB  = 4'b1010;

    typedef enum logic [1:0] {
        LD_IDLE = 2'b00,
        LD_REQ  = 2'b01,
        LD_WAIT = 2'b10,
        LD_RESP = 2'b11
    } load_state_e;

    function automatic logic is_load_op(input logic [3:0] op);
        case (op)
            LD_LW, LD_LH, LD_LB, LD_LHU, LD_LBU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_lane_extract.sv
// Selects the byte/half lane of a read word and sign- or zero-extends it,
// using the same lane map as the store-path byte mask.
module load_lane_extract
    import riscv_mem_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  byte_addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select and extension; unknown opcodes yield zero.
    always_comb begin
        byte_s = rdata[{byte_addr, 3'b000} +: 8];
        half_s = byte_addr[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            LD_LW:   data = rdata;
            LD_LH:   data = {{16{half_s[15]}}, half_s};
            LD_LHU:  data = {16'h0000, half_s};
            LD_LB:   data = {{24{byte_s[7]}}, byte_s};
            LD_LBU:  data = {24'h00_0000, byte_s};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load path: accepts one load, issues a word-aligned read, extracts and
// extends the addressed lane, and returns it to writeback with a timeout.
module load_align_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [3:0]        ld_op,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [TAG_W-1:0]  ld_tag,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    load_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [3:0]        op_r;
    logic [1:0]        lane_r;
    logic [TAG_W-1:0]  tag_r;
    logic [ADDR_W-1:0] addr_r;
    logic              ld_ready_r, mem_req_valid_r, res_valid_r, res_err_r;
    logic [31:0]       res_data_r;
    logic [31:0]       res_data_nxt_s;
    logic              res_err_nxt_s;
    logic              accept_s;
    logic [31:0]       lane_data_s;

    assign accept_s = ld_valid & ld_ready_r;

    load_lane_extract u_extract (
        .op        (op_r),
        .byte_addr (lane_r),
        .rdata     (mem_rdata),
        .data      (lane_data_s)
    );

    // Next-state, timeout counter and result selection.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        res_data_nxt_s = res_data_r;
        res_err_nxt_s  = res_err_r;
        case (state_r)
            LD_IDLE: begin
                if (accept_s) begin
                    if (is_load_op(ld_op)) begin
                        state_nxt_s = LD_REQ;
                    end else begin
                        state_nxt_s    = LD_RESP;
                        res_data_nxt_s = 32'h0000_0000;
                        res_err_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = LD_IDLE;
                end
            end
            LD_REQ: begin
                if (mem_req_ready) begin
                    state_nxt_s = LD_WAIT;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = LD_REQ;
                end
            end
            LD_WAIT: begin
                // Data arriving in the timeout cycle takes priority over the error.
                if (mem_rvalid) begin
                    state_nxt_s    = LD_RESP;
                    res_data_nxt_s = lane_data_s;
                    res_err_nxt_s  = 1'b0;
                end else if ((TIMEOUT != 0) && (cnt_r == TO_LAST)) begin
                    state_nxt_s    = LD_RESP;
                    res_data_nxt_s = 32'h0000_0000;
                    res_err_nxt_s  = 1'b1;
                end else if (cnt_r != {CNT_W{1'b1}}) begin
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            LD_RESP: begin
                if (res_ready) begin
                    state_nxt_s = LD_IDLE;
                end else begin
                    state_nxt_s = LD_RESP;
                end
            end
            default: begin
                state_nxt_s = LD_IDLE;
            end
        endcase
    end

    // State, registered handshake outputs and captured command fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r         <= LD_IDLE;
            cnt_r           <= '0;
            op_r            <= 4'h0;
            lane_r          <= 2'b00;
            tag_r           <= '0;
            addr_r          <= '0;
            ld_ready_r      <= 1'b0;
            mem_req_valid_r <= 1'b0;
            res_valid_r     <= 1'b0;
            res_err_r       <= 1'b0;
            res_data_r      <= 32'h0000_0000;
        end else begin
            state_r         <= state_nxt_s;
            cnt_r           <= cnt_nxt_s;
            ld_ready_r      <= (state_nxt_s == LD_IDLE);
            mem_req_valid_r <= (state_nxt_s == LD_REQ);
            res_valid_r     <= (state_nxt_s == LD_RESP);
            res_err_r       <= res_err_nxt_s;
            res_data_r      <= res_data_nxt_s;
            if (accept_s) begin
                op_r   <= ld_op;
                lane_r <= ld_addr[1:0];
                tag_r  <= ld_tag;
                addr_r <= {ld_addr[ADDR_W-1:2], 2'b00};
            end
        end
    end

    assign ld_ready      = ld_ready_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = addr_r;
    assign res_valid     = res_valid_r;
    assign res_data      = res_data_r;
    assign res_tag       = tag_r;
    assign res_err       = res_err_r;

endmodule
